// File: rtl/matrix_scalar_multiply_decoder.sv
// matrix_scalar_multiply_decoder: multiplies each of 9 matrix elements by a captured scalar with a
// shift-add loop, returning every product in binary and as a 16-line one-hot code.
module matrix_scalar_multiply_decoder #(
    parameter int DATA_W   = 16,
    parameter int SCALAR_W = 4,
    parameter int ELEMS    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SCALAR_W-1:0] scalar,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_prod,
    output logic                out_ovf,
    output logic [15:0]         out_onehot,
    output logic [3:0]          out_idx,
    output logic                out_last,
    output logic                busy,
    output logic                done
);
    localparam int AW = DATA_W + SCALAR_W;
    localparam int CW = SCALAR_W > 1 ? $clog2(SCALAR_W) : 1;
    typedef enum logic [1:0] {IDLE, WAIT_IN, MUL, OUT} state_t;
    state_t state;
    logic [SCALAR_W-1:0] scal;
    logic [DATA_W-1:0] mcand;
    logic [AW-1:0] acc, acc_nx;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic last_iter;
    logic [15:0] onehot_nx;
    // acc_nx already holds the final product during the last iteration
    always_comb begin
        acc_nx = acc + (scal[cnt] ? AW'(mcand) << cnt : '0);
        last_iter = cnt == CW'(SCALAR_W - 1);
        onehot_nx = acc_nx < AW'(16) ? 16'd1 << acc_nx[3:0] : 16'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            scal <= '0;
            mcand <= '0;
            acc <= '0;
            cnt <= '0;
            idx <= '0;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            out_prod <= '0;
            out_ovf <= 1'b0;
            out_onehot <= '0;
            out_idx <= '0;
            out_last <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    scal <= scalar;
                    idx <= '0;
                    in_ready <= 1'b1;
                    busy <= 1'b1;
                    state <= WAIT_IN;
                end
                WAIT_IN: if (in_valid) begin
                    mcand <= in_data;
                    acc <= '0;
                    cnt <= '0;
                    in_ready <= 1'b0;
                    state <= MUL;
                end
                MUL: begin
                    acc <= acc_nx;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        out_valid <= 1'b1;
                        out_prod <= acc_nx[DATA_W-1:0];
                        out_ovf <= |acc_nx[AW-1:DATA_W];
                        out_onehot <= onehot_nx;
                        out_idx <= idx;
                        out_last <= idx == 4'(ELEMS - 1);
                        state <= OUT;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (idx < 4'(ELEMS - 1)) begin
                        idx <= idx + 4'd1;
                        in_ready <= 1'b1;
                        state <= WAIT_IN;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
